// File: rtl/dp_cu_param.sv
// dp_cu_param: parametrised go/done arithmetic unit (add, sub, and, shift-add mul)
// with a small control FSM whose state code is exported for a 7-segment display.
module dp_cu_param #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               go,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   in1,
    input  logic [WIDTH-1:0]   in2,
    output logic [2:0]         cs,
    output logic               busy,
    output logic               done,
    output logic               neg,
    output logic [2*WIDTH-1:0] out
);

    // Iteration counter only ever needs to reach WIDTH-1.
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_MUL = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_EXEC = 3'd2,
        ST_MUL  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [1:0]         opr_q, opr_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] out_q, out_d;
    logic               neg_q, neg_d;

    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] b_ext;
    logic [2*WIDTH-1:0] mul_acc;

    // Zero-extended operands and the accumulator value after one shift-add step.
    always_comb begin
        a_ext   = {{WIDTH{1'b0}}, a_q};
        b_ext   = {{WIDTH{1'b0}}, b_q};
        mul_acc = acc_q;
        if (b_q[0]) begin
            mul_acc = acc_q + (a_ext << cnt_q);
        end
    end

    // Next-state and datapath control; the result register only moves on entry to DONE.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        opr_d   = opr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        neg_d   = neg_q;

        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    state_d = ST_LOAD;
                end
            end

            ST_LOAD: begin
                a_d     = in1;
                b_d     = in2;
                opr_d   = op;
                acc_d   = '0;
                cnt_d   = '0;
                state_d = (op == OP_MUL) ? ST_MUL : ST_EXEC;
            end

            ST_EXEC: begin
                neg_d = 1'b0;
                case (opr_q)
                    OP_ADD: out_d = a_ext + b_ext;
                    OP_SUB: begin
                        out_d = {{WIDTH{1'b0}}, a_q - b_q};
                        neg_d = (a_q < b_q);
                    end
                    OP_AND: out_d = {{WIDTH{1'b0}}, a_q & b_q};
                    default: out_d = '0;
                endcase
                state_d = ST_DONE;
            end

            ST_MUL: begin
                acc_d = mul_acc;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    out_d   = mul_acc;
                    neg_d   = 1'b0;
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                if (!go) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            opr_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            opr_q   <= opr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            neg_q   <= neg_d;
        end
    end

    // Status outputs are decoded straight from the state register.
    always_comb begin
        cs   = state_q;
        busy = (state_q == ST_LOAD) || (state_q == ST_EXEC) || (state_q == ST_MUL);
        done = (state_q == ST_DONE);
        neg  = neg_q;
        out  = out_q;
    end

    // Keep the otherwise-unused upper bits of b_ext visible to tools as intentional.
    logic unused_b_ext;
    always_comb begin
        unused_b_ext = ^b_ext;
    end

endmodule

// File: tb/tb_dp_cu_param.sv
// Testbench for dp_cu_param: a WIDTH=4 and a WIDTH=8 instance driven with directed
// and random operations, checked cycle by cycle against an arithmetic reference model.
module tb_dp_cu_param;

   logic clk;
   logic rst;
   logic go4, go8;
   logic [1:0] opIn;
   logic [7:0] in1, in2;

   logic [2:0]  cs4, cs8;
   logic        busy4, busy8, done4, done8, neg4, neg8;
   logic [7:0]  out4;
   logic [15:0] out8;

   int checkCount;
   int failCount;

   // Last result each instance should be holding, indexed 0 for WIDTH=4, 1 for WIDTH=8.
   logic [15:0] lastOut [2];
   logic        lastNeg [2];

   dp_cu_param #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .go(go4), .op(opIn), .in1(in1[3:0]), .in2(in2[3:0]),
      .cs(cs4), .busy(busy4), .done(done4), .neg(neg4), .out(out4)
   );

   dp_cu_param #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .go(go8), .op(opIn), .in1(in1), .in2(in2),
      .cs(cs8), .busy(busy8), .done(done8), .neg(neg8), .out(out8)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, observed, expected, $time);
      end
   endtask

   // Read the outputs of the selected instance.
   task automatic sampleDut(input int w, output logic [2:0] c, output logic [15:0] r,
                            output logic n, output logic d, output logic b);
      if (w == 8) begin
         c = cs8; r = out8; n = neg8; d = done8; b = busy8;
      end else begin
         c = cs4; r = {8'h00, out4}; n = neg4; d = done4; b = busy4;
      end
   endtask

   task automatic setGo(input int w, input logic v);
      if (w == 8) go8 = v;
      else go4 = v;
   endtask

   // Full operation on one instance: called #1 after a rising edge with that instance in IDLE.
   task automatic applyStimulus(input int w, input logic [1:0] o, input logic [7:0] a,
                                input logic [7:0] b, input bit holdGo);
      logic [15:0] mask, ea, eb, expOut;
      logic        expNeg;
      int          expCs[$];
      int          idx;
      logic [2:0]  c;
      logic [15:0] r;
      logic        n, d, bz;

      idx    = (w == 8) ? 1 : 0;
      mask   = (w == 8) ? 16'h00FF : 16'h000F;
      ea     = {8'h00, a} & mask;
      eb     = {8'h00, b} & mask;
      expNeg = 1'b0;
      case (o)
         2'b00: expOut = ea + eb;
         2'b01: begin
            expOut = (ea - eb) & mask;
            expNeg = (ea < eb);
         end
         2'b10: expOut = ea & eb;
         default: expOut = ea * eb;
      endcase

      expCs.push_back(1);
      if (o == 2'b11) begin
         for (int k = 0; k < w; k++) expCs.push_back(3);
      end else begin
         expCs.push_back(2);
      end
      expCs.push_back(4);

      in1  = a;
      in2  = b;
      opIn = o;
      setGo(w, 1'b1);

      for (int i = 0; i < expCs.size(); i++) begin
         @(posedge clk);
         #1;
         sampleDut(w, c, r, n, d, bz);
         checkOutput("cs", {29'd0, c}, expCs[i]);
         checkOutput("busy", {31'd0, bz}, {31'd0, expCs[i] != 4});
         checkOutput("done", {31'd0, d}, {31'd0, expCs[i] == 4});
         if (expCs[i] == 4) begin
            checkOutput("out", {16'd0, r}, {16'd0, expOut});
            checkOutput("neg", {31'd0, n}, {31'd0, expNeg});
         end else begin
            checkOutput("outHeld", {16'd0, r}, {16'd0, lastOut[idx]});
            checkOutput("negHeld", {31'd0, n}, {31'd0, lastNeg[idx]});
         end
         if (i >= 1) begin
            in1  = 8'($urandom);
            in2  = 8'($urandom);
            opIn = 2'($urandom_range(0, 3));
         end
         if (!holdGo) begin
            if (i < expCs.size() - 1) setGo(w, 1'($urandom_range(0, 1)));
            else setGo(w, 1'b0);
         end
      end

      lastOut[idx] = expOut;
      lastNeg[idx] = expNeg;

      if (holdGo) begin
         for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            sampleDut(w, c, r, n, d, bz);
            checkOutput("csHold", {29'd0, c}, 32'd4);
            checkOutput("outHold", {16'd0, r}, {16'd0, expOut});
         end
         setGo(w, 1'b0);
      end

      @(posedge clk);
      #1;
      sampleDut(w, c, r, n, d, bz);
      checkOutput("csIdle", {29'd0, c}, 32'd0);
      checkOutput("doneIdle", {31'd0, d}, 32'd0);
      checkOutput("outIdle", {16'd0, r}, {16'd0, expOut});
      checkOutput("negIdle", {31'd0, n}, {31'd0, expNeg});
   endtask

   initial begin
      logic [2:0]  c;
      logic [15:0] r;
      logic        n, d, bz;
      int          w;

      checkCount = 0;
      failCount  = 0;
      rst  = 1'b0;
      go4  = 1'b0;
      go8  = 1'b0;
      opIn = 2'b00;
      in1  = 8'h00;
      in2  = 8'h00;
      for (int k = 0; k < 2; k++) begin
         lastOut[k] = 16'h0000;
         lastNeg[k] = 1'b0;
      end

      #2 rst = 1'b1;
      #2;
      for (int k = 0; k < 2; k++) begin
         w = (k == 1) ? 8 : 4;
         sampleDut(w, c, r, n, d, bz);
         checkOutput("rstCs", {29'd0, c}, 32'd0);
         checkOutput("rstOut", {16'd0, r}, 32'd0);
         checkOutput("rstFlags", {29'd0, n, d, bz}, 32'd0);
      end
      @(posedge clk);
      #1 rst = 1'b0;

      // Directed cases from the WIDTH=4 scenarios.
      applyStimulus(4, 2'b00, 8'd7, 8'd9, 1'b0);
      applyStimulus(4, 2'b01, 8'd3, 8'd5, 1'b0);
      applyStimulus(4, 2'b01, 8'd5, 8'd3, 1'b0);
      applyStimulus(4, 2'b10, 8'd12, 8'd10, 1'b0);
      applyStimulus(4, 2'b11, 8'd15, 8'd15, 1'b0);
      applyStimulus(4, 2'b11, 8'd0, 8'd13, 1'b1);
      applyStimulus(4, 2'b00, 8'd15, 8'd15, 1'b1);

      // Asynchronous reset between edges in the middle of a multiply.
      in1  = 8'd9;
      in2  = 8'd11;
      opIn = 2'b11;
      go4  = 1'b1;
      @(posedge clk);
      #1 go4 = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      sampleDut(4, c, r, n, d, bz);
      checkOutput("midRstCs", {29'd0, c}, 32'd0);
      checkOutput("midRstOut", {16'd0, r}, 32'd0);
      checkOutput("midRstDone", {31'd0, d}, 32'd0);
      checkOutput("midRstBusy", {31'd0, bz}, 32'd0);
      #1 rst = 1'b0;
      lastOut[0] = 16'h0000;
      lastNeg[0] = 1'b0;
      lastOut[1] = 16'h0000;
      lastNeg[1] = 1'b0;
      @(posedge clk);
      #1;
      applyStimulus(4, 2'b11, 8'd6, 8'd7, 1'b0);

      // WIDTH=8 boundary cases.
      applyStimulus(8, 2'b11, 8'd255, 8'd255, 1'b0);
      applyStimulus(8, 2'b00, 8'd255, 8'd1, 1'b0);
      applyStimulus(8, 2'b01, 8'd0, 8'd255, 1'b1);

      // Random operations on either instance.
      for (int k = 0; k < 24; k++) begin
         applyStimulus(($urandom_range(0, 1) == 1) ? 8 : 4, 2'($urandom_range(0, 3)),
                       8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL timeout: got running expected finished");
      $fatal(1, "[TB] time limit reached");
   end

endmodule
